// File: rtl/rf_writeback_scheduler.sv
// rf_writeback_scheduler
//   Drives the two register-file write ports of the dual-issue SPU. The even
//   pipe always gets its write one cycle after its writeback request. The odd
//   pipe writes through a candidate selector. The candidate is the FIFO head
//   when the FIFO holds anything, otherwise the incoming accepted request.
//   When the candidate targets the same RT as a same-cycle even write, the odd
//   write is deferred into a small holding FIFO. The odd (younger) value
//   therefore lands after the even one.
//   A 128-entry busy scoreboard is set at issue and cleared when the register
//   file captures the write.
//
// Ports
//   clock, reset                    rising-edge clock, async active-high reset
//   ep_wb_valid/addr/data           even-pipe writeback request (never stalled)
//   op_wb_valid/addr/data           odd-pipe writeback request
//   op_wb_ready                     odd request accepted this cycle
//   issue_ep_valid/rt               even issue with target RT (sets busy)
//   issue_op_valid/rt               odd issue with target RT (sets busy)
//   wrt_en_ep, rt_ep_address,
//   rt_value_ep                     registered RF even write port
//   wrt_en_op, rt_op_address,
//   rt_value_op                     registered RF odd write port
//   busy_vec                        bit n = register n has a write outstanding
//   op_pending                      holding FIFO occupancy
//   op_overflow_err                 sticky: odd request presented while not ready
//
// Handshake: an odd request transfers on a cycle where op_wb_valid and
// op_wb_ready are both 1. op_wb_ready depends only on registered occupancy,
// never on op_wb_valid. A request presented while op_wb_ready is 0 is
// dropped and flagged. The pipe is expected to hold it until ready returns.

module rf_writeback_scheduler #(
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ep_wb_valid,
  input  logic [ADDR_W-1:0]            ep_wb_addr,
  input  logic [DATA_W-1:0]            ep_wb_data,
  input  logic                         op_wb_valid,
  input  logic [ADDR_W-1:0]            op_wb_addr,
  input  logic [DATA_W-1:0]            op_wb_data,
  output logic                         op_wb_ready,
  input  logic                         issue_ep_valid,
  input  logic [ADDR_W-1:0]            issue_ep_rt,
  input  logic                         issue_op_valid,
  input  logic [ADDR_W-1:0]            issue_op_rt,
  output logic                         wrt_en_ep,
  output logic [ADDR_W-1:0]            rt_ep_address,
  output logic [DATA_W-1:0]            rt_value_ep,
  output logic                         wrt_en_op,
  output logic [ADDR_W-1:0]            rt_op_address,
  output logic [DATA_W-1:0]            rt_value_op,
  output logic [2**ADDR_W-1:0]         busy_vec,
  output logic [$clog2(BUF_DEPTH):0]   op_pending,
  output logic                         op_overflow_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  // Holding FIFO storage; pointers wrap naturally since depth is a power of two.
  logic [ADDR_W-1:0] fifo_addr [BUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              fifo_empty;
  logic              op_accept;
  logic              cand_valid;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_data;
  logic              collide;
  logic              op_issue;
  logic              push;
  logic              pop;
  logic [NREG-1:0]   busy_next;

  assign fifo_empty  = (count == '0);
  // Held low during reset so every output reads 0 while reset is asserted.
  assign op_wb_ready = !reset && (count < DEPTH_C);
  assign op_accept   = op_wb_valid && op_wb_ready;
  assign op_pending  = count;

  always_comb begin
    cand_valid = 1'b0;
    cand_addr  = op_wb_addr;
    cand_data  = op_wb_data;
    if (!fifo_empty) begin
      cand_valid = 1'b1;
      cand_addr  = fifo_addr[rd_ptr];
      cand_data  = fifo_data[rd_ptr];
    end else begin
      cand_valid = op_accept;
    end
    // Even wins a same-RT collision; the odd candidate waits a cycle.
    collide  = cand_valid && ep_wb_valid && (cand_addr == ep_wb_addr);
    op_issue = cand_valid && !collide;
    pop      = op_issue && !fifo_empty;
    // An accepted request goes into the FIFO unless it was issued directly.
    // Space is guaranteed because acceptance requires count < depth.
    push     = op_accept && (!fifo_empty || collide);
  end

  // Scoreboard update: clear on RF capture, then set on issue so set wins.
  always_comb begin
    busy_next = busy_vec;
    if (wrt_en_ep)      busy_next[rt_ep_address] = 1'b0;
    if (wrt_en_op)      busy_next[rt_op_address] = 1'b0;
    if (issue_ep_valid) busy_next[issue_ep_rt]   = 1'b1;
    if (issue_op_valid) busy_next[issue_op_rt]   = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= op_wb_addr;
      fifo_data[wr_ptr] <= op_wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrt_en_ep       <= 1'b0;
      rt_ep_address   <= '0;
      rt_value_ep     <= '0;
      wrt_en_op       <= 1'b0;
      rt_op_address   <= '0;
      rt_value_op     <= '0;
      busy_vec        <= '0;
      op_overflow_err <= 1'b0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
    end else begin
      wrt_en_ep <= ep_wb_valid;
      if (ep_wb_valid) begin
        rt_ep_address <= ep_wb_addr;
        rt_value_ep   <= ep_wb_data;
      end
      wrt_en_op <= op_issue;
      if (op_issue) begin
        rt_op_address <= cand_addr;
        rt_value_op   <= cand_data;
      end
      busy_vec <= busy_next;
      if (op_wb_valid && !op_wb_ready) op_overflow_err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
module tb_rf_writeback_scheduler;

  localparam int DEPTH = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         ep_wb_valid;
  logic [6:0]   ep_wb_addr;
  logic [127:0] ep_wb_data;
  logic         op_wb_valid;
  logic [6:0]   op_wb_addr;
  logic [127:0] op_wb_data;
  logic         op_wb_ready;
  logic         issue_ep_valid;
  logic [6:0]   issue_ep_rt;
  logic         issue_op_valid;
  logic [6:0]   issue_op_rt;
  logic         wrt_en_ep;
  logic [6:0]   rt_ep_address;
  logic [127:0] rt_value_ep;
  logic         wrt_en_op;
  logic [6:0]   rt_op_address;
  logic [127:0] rt_value_op;
  logic [127:0] busy_vec;
  logic [1:0]   op_pending;
  logic         op_overflow_err;

  // clock / reset
  always #5 clock = ~clock;

  rf_writeback_scheduler #(.BUF_DEPTH(DEPTH), .DATA_W(128), .ADDR_W(7)) dut (
    .clock(clock), .reset(reset),
    .ep_wb_valid(ep_wb_valid), .ep_wb_addr(ep_wb_addr), .ep_wb_data(ep_wb_data),
    .op_wb_valid(op_wb_valid), .op_wb_addr(op_wb_addr), .op_wb_data(op_wb_data),
    .op_wb_ready(op_wb_ready),
    .issue_ep_valid(issue_ep_valid), .issue_ep_rt(issue_ep_rt),
    .issue_op_valid(issue_op_valid), .issue_op_rt(issue_op_rt),
    .wrt_en_ep(wrt_en_ep), .rt_ep_address(rt_ep_address), .rt_value_ep(rt_value_ep),
    .wrt_en_op(wrt_en_op), .rt_op_address(rt_op_address), .rt_value_op(rt_value_op),
    .busy_vec(busy_vec), .op_pending(op_pending), .op_overflow_err(op_overflow_err)
  );

  // reference model: pending odd writes in arrival order
  typedef struct packed {
    logic [6:0]   a;
    logic [127:0] d;
  } wr_t;

  wr_t          pend_q[$];
  logic         m_en_ep, m_en_op, m_err;
  logic [6:0]   m_ep_a, m_op_a;
  logic [127:0] m_ep_d, m_op_d, m_busy;
  logic [127:0] rf_m [128];
  logic [127:0] rf_d [128];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_en_ep = 1'b0; m_en_op = 1'b0; m_err = 1'b0;
    m_ep_a = '0; m_op_a = '0; m_ep_d = '0; m_op_d = '0; m_busy = '0;
  endtask

  // One clock edge of the behavioural rules, using the inputs currently driven.
  task automatic model_edge();
    if (m_en_ep) begin rf_m[m_ep_a] = m_ep_d; m_busy[m_ep_a] = 1'b0; end
    if (m_en_op) begin rf_m[m_op_a] = m_op_d; m_busy[m_op_a] = 1'b0; end
    if (issue_ep_valid) m_busy[issue_ep_rt] = 1'b1;
    if (issue_op_valid) m_busy[issue_op_rt] = 1'b1;
    if (op_wb_valid) begin
      if (pend_q.size() < DEPTH) pend_q.push_back('{a: op_wb_addr, d: op_wb_data});
      else m_err = 1'b1;
    end
    m_en_ep = ep_wb_valid;
    if (ep_wb_valid) begin m_ep_a = ep_wb_addr; m_ep_d = ep_wb_data; end
    m_en_op = 1'b0;
    if (pend_q.size() > 0 && !(ep_wb_valid && pend_q[0].a == ep_wb_addr)) begin
      m_en_op = 1'b1;
      m_op_a  = pend_q[0].a;
      m_op_d  = pend_q[0].d;
      void'(pend_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    check("wrt_en_ep", wrt_en_ep, m_en_ep);
    check("rt_ep_address", rt_ep_address, m_ep_a);
    check("rt_value_ep", rt_value_ep, m_ep_d);
    check("wrt_en_op", wrt_en_op, m_en_op);
    check("rt_op_address", rt_op_address, m_op_a);
    check("rt_value_op", rt_value_op, m_op_d);
    check("busy_vec", busy_vec, m_busy);
    check("op_pending", op_pending, pend_q.size());
    check("op_overflow_err", op_overflow_err, m_err);
  endtask

  // driver: one cycle of stimulus, then compare against the model
  task automatic drive(input logic ev, input logic [6:0] ea, input logic [127:0] ed,
                       input logic ov, input logic [6:0] oa, input logic [127:0] od,
                       input logic iev, input logic [6:0] iert,
                       input logic iov, input logic [6:0] iort);
    ep_wb_valid = ev; ep_wb_addr = ea; ep_wb_data = ed;
    op_wb_valid = ov; op_wb_addr = oa; op_wb_data = od;
    issue_ep_valid = iev; issue_ep_rt = iert;
    issue_op_valid = iov; issue_op_rt = iort;
    #1;
    check("op_wb_ready", op_wb_ready, pend_q.size() < DEPTH);
    // RF capture of whatever the DUT presents at the coming edge
    if (wrt_en_ep) rf_d[rt_ep_address] = rt_value_ep;
    if (wrt_en_op) rf_d[rt_op_address] = rt_value_op;
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    ep_wb_valid = 0; op_wb_valid = 0; issue_ep_valid = 0; issue_op_valid = 0;
    #2 reset = 1'b1;
    #2;
    model_reset();
    check("rst wrt_en_ep", wrt_en_ep, 1'b0);
    check("rst wrt_en_op", wrt_en_op, 1'b0);
    check("rst busy_vec", busy_vec, '0);
    check("rst op_pending", op_pending, 0);
    check("rst op_overflow_err", op_overflow_err, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst op_wb_ready", op_wb_ready, 1'b1);
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d_a, d_b, d_c;
    for (int i = 0; i < 128; i++) begin rf_m[i] = '0; rf_d[i] = '0; end
    reset = 1'b1;
    ep_wb_valid = 0; ep_wb_addr = 0; ep_wb_data = '0;
    op_wb_valid = 0; op_wb_addr = 0; op_wb_data = '0;
    issue_ep_valid = 0; issue_ep_rt = 0; issue_op_valid = 0; issue_op_rt = 0;
    model_reset();
    repeat (2) @(posedge clock);
    do_reset();

    // different addresses: both ports write together
    drive(1, 5, {32{4'hA}}, 1, 9, {32{4'h5}}, 0, 0, 0, 0);
    check("diff wrt_en_ep", wrt_en_ep, 1'b1);
    check("diff wrt_en_op", wrt_en_op, 1'b1);
    check("diff rt_op_address", rt_op_address, 7'd9);
    check("diff op_pending", op_pending, 0);

    // same-RT collision: even first, odd one cycle later and final
    drive(1, 12, {16{8'h11}}, 1, 12, {16{8'h22}}, 0, 0, 0, 0);
    check("coll wrt_en_op", wrt_en_op, 1'b0);
    check("coll op_pending", op_pending, 1);
    idle();
    check("coll late wrt_en_op", wrt_en_op, 1'b1);
    check("coll late value", rt_value_op, {16{8'h22}});
    idle();
    check("coll rf12", rf_d[12], {16{8'h22}});

    // three collisions on RT 3: FIFO fills, third request held by the pipe
    d_a = rnd_data(); d_b = rnd_data(); d_c = rnd_data();
    drive(1, 3, rnd_data(), 1, 3, d_a, 0, 0, 0, 0);
    drive(1, 3, rnd_data(), 1, 3, d_b, 0, 0, 0, 0);
    check("full ready", op_wb_ready, 1'b0);
    check("full pending", op_pending, 2);
    drive(1, 3, rnd_data(), 0, 3, d_c, 0, 0, 0, 0);
    drive(0, 0, '0, 0, 3, d_c, 0, 0, 0, 0);
    drive(0, 0, '0, 1, 3, d_c, 0, 0, 0, 0);
    idle(); idle();
    check("drain rf3", rf_d[3], d_c);
    check("drain no err", op_overflow_err, 1'b0);

    // scoreboard on RT 7
    drive(0, 0, '0, 0, 0, '0, 1, 7, 0, 0);
    check("busy7 set", busy_vec[7], 1'b1);
    drive(1, 7, rnd_data(), 0, 0, '0, 0, 0, 0, 0);
    drive(0, 0, '0, 0, 0, '0, 1, 7, 0, 0);
    check("busy7 reissue", busy_vec[7], 1'b1);
    drive(1, 7, rnd_data(), 0, 0, '0, 0, 0, 0, 0);
    idle();
    check("busy7 clear", busy_vec[7], 1'b0);

    // randomized traffic from a well-behaved odd pipe
    for (int i = 0; i < 400; i++) begin
      logic ov;
      ov = ($urandom_range(0, 3) != 0) && (pend_q.size() < DEPTH);
      drive($urandom_range(0, 1), 7'($urandom_range(0, 7)), rnd_data(),
            ov, 7'($urandom_range(0, 7)), rnd_data(),
            $urandom_range(0, 1), 7'($urandom_range(0, 15)),
            $urandom_range(0, 1), 7'($urandom_range(0, 15)));
    end
    repeat (3) idle();

    // overflow: present a request while full
    drive(1, 4, rnd_data(), 1, 4, rnd_data(), 0, 0, 0, 0);
    drive(1, 4, rnd_data(), 1, 4, rnd_data(), 0, 0, 0, 0);
    drive(0, 0, '0, 1, 20, rnd_data(), 0, 0, 0, 0);
    check("ovf err set", op_overflow_err, 1'b1);
    repeat (3) idle();
    check("ovf err sticky", op_overflow_err, 1'b1);
    check("ovf dropped", rf_d[20], '0);

    // reset mid-stream with two deferred entries and busy bits
    drive(1, 6, rnd_data(), 1, 6, rnd_data(), 1, 30, 1, 31);
    drive(1, 6, rnd_data(), 1, 6, rnd_data(), 0, 0, 0, 0);
    check("pre-rst pending", op_pending, 2);
    do_reset();
    check("post-rst err", op_overflow_err, 1'b0);
    repeat (3) idle();

    for (int i = 0; i < 128; i++) check($sformatf("rf[%0d]", i), rf_d[i], rf_m[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
- Sequences the two register-file write ports (even pipe, odd pipe) of the dual-issue SPU and tracks register busy state.
- Resolves same-cycle same-RT collisions by giving the even write the port and deferring the odd write into a small holding FIFO, which back-pressures the odd pipe.
- Maintains a 128-entry busy scoreboard, set at issue and cleared at RF commit, so issue logic can block RAW/WAW hazards against deferred writes.
- Sits between the pipe writeback stages and the 128 x 128-bit register file.

Parameters:
- BUF_DEPTH, 2, odd-pipe holding FIFO entries (power of two, >=2)
- DATA_W, 128, register width in bits
- ADDR_W, 7, register address width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ep_wb_valid  in  1  even-pipe writeback request (never stalled)
- ep_wb_addr  in  ADDR_W  even RT address
- ep_wb_data  in  DATA_W  even RT value
- op_wb_valid  in  1  odd-pipe writeback request
- op_wb_addr  in  ADDR_W  odd RT address
- op_wb_data  in  DATA_W  odd RT value
- op_wb_ready  out  1  odd request accepted this cycle; low = stall odd pipe
- issue_ep_valid  in  1  even instruction issued with a target RT
- issue_ep_rt  in  ADDR_W  its RT
- issue_op_valid  in  1  odd instruction issued with a target RT
- issue_op_rt  in  ADDR_W  its RT
- wrt_en_ep  out  1  RF even write enable (registered)
- rt_ep_address  out  ADDR_W  RF even write address (registered)
- rt_value_ep  out  DATA_W  RF even write data (registered)
- wrt_en_op  out  1  RF odd write enable (registered)
- rt_op_address  out  ADDR_W  RF odd write address (registered)
- rt_value_op  out  DATA_W  RF odd write data (registered)
- busy_vec  out  128  bit n = register n has a write outstanding
- op_pending  out  clog2(BUF_DEPTH)+1  FIFO occupancy
- op_overflow_err  out  1  sticky: op_wb_valid seen while op_wb_ready=0

Behaviour:
- Reset: all outputs 0, FIFO empty, busy_vec all 0, op_wb_ready=1 once reset deasserts. Reset mid-operation drops FIFO contents and scheduled writes; no RF write occurs in the cycle after reset.
- Even path: ep_wb_valid -> next edge wrt_en_ep=1, address/data registered. Latency 1, unconditional. wrt_en_ep=0 otherwise; address/data hold last value.
- Odd candidate each cycle: FIFO head if FIFO non-empty, else incoming accepted request. Strict FIFO order; incoming never bypasses the FIFO.
- Collision: candidate valid, ep_wb_valid=1, and addresses equal -> odd candidate not issued this cycle (even wins). If the candidate was incoming, it is pushed into the FIFO. Odd value is written the following cycle at the earliest, so the odd (younger) value is final in the RF.
- No collision: candidate issued -> next edge wrt_en_op=1 with its address/data. If the candidate is the FIFO head, pop; incoming (if any) is pushed in the same cycle.
- Different addresses never block; both ports write in the same cycle.
- op_wb_ready = (op_pending < BUF_DEPTH), from registered occupancy only. Push+pop in the same cycle keeps occupancy. Full with a head pop still shows ready=0 that cycle.
- op_wb_valid while ready=0: request dropped, op_overflow_err set; cleared only by reset.
- Scoreboard: busy[issue_*_rt] set at the edge after issue_*_valid. Busy clears at the edge where the RF captures the write (wrt_en_*=1 for that address). Same-address set and clear at one edge: set wins. Both issues to the same RT: set once.
- busy_vec is a direct register output.

Test Plan:
- Reset mid-stream with FIFO holding 2 entries -> op_pending=0, busy_vec=0, wrt_en_*=0, op_wb_ready=1 after deassert.
- Even write addr 5, data 0xA..A, odd write addr 9 same cycle -> next cycle wrt_en_ep=1 (5) and wrt_en_op=1 (9); op_pending stays 0.
- Both write addr 12 (even 0x11.., odd 0x22..) -> cycle+1 only wrt_en_ep (12). Cycle+2 wrt_en_op (12, 0x22..). Final RF[12]=0x22..; op_pending peaks at 1.
- Collide on addr 3 for 3 consecutive cycles with BUF_DEPTH=2 -> op_wb_ready=0 after 2 pushes. The third odd request is held by the pipe (no error). Entries drain in order once even stops colliding.
- Issue even RT 7 -> busy_vec[7]=1 next cycle. Write to 7 committed -> busy_vec[7]=0 after that edge. Re-issue to 7 on the commit cycle -> bit stays 1.
- Drive op_wb_valid while op_wb_ready=0 -> op_overflow_err=1 and stays 1 until reset; no RF write for the dropped request.
